// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: ALU, load, hazard-query and register-file write signals of the writeback arbiter
interface wb_arbiter_if #(
    parameter int XLEN = 32
);
    logic            alu_valid;
    logic            alu_ready;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            ld_valid;
    logic            ld_ready;
    logic [4:0]      ld_rd;
    logic [XLEN-1:0] ld_data;
    logic [4:0]      rs_addr1;
    logic [4:0]      rs_addr2;
    logic            busy1;
    logic            busy2;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;

    modport slave (
        input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, rs_addr1, rs_addr2,
        output alu_ready, ld_ready, busy1, busy2, rf_we, rf_waddr, rf_wdata
    );

    modport master (
        output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, rs_addr1, rs_addr2,
        input  alu_ready, ld_ready, busy1, busy2, rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU results and FIFO-buffered load results onto the single register-file write port
module wb_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3,
    parameter int XLEN         = 32
) (
    input logic         clk,
    input logic         rst,
    wb_arbiter_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]      fifo_rd   [DEPTH];
    logic [XLEN-1:0] fifo_data [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic [SW-1:0]   starve_cnt;
    logic            nonempty;
    logic            force_pri;
    logic            ld_ready;
    logic            alu_win;
    logic            pop;
    logic            push;
    logic            hit1;
    logic            hit2;

    assign nonempty      = count != '0;
    assign force_pri     = nonempty && starve_cnt == SW'(STARVE_LIMIT);
    assign ld_ready      = count < (AW+1)'(DEPTH);
    assign alu_win       = bus.alu_valid && !force_pri && bus.alu_rd != '0;
    assign pop           = nonempty && !alu_win;
    assign push          = bus.ld_valid && ld_ready && bus.ld_rd != '0;
    assign bus.alu_ready = !force_pri;
    assign bus.ld_ready  = ld_ready;
    assign bus.busy1     = bus.rs_addr1 != '0 && (hit1 || (bus.rf_we && bus.rf_waddr == bus.rs_addr1));
    assign bus.busy2     = bus.rs_addr2 != '0 && (hit2 || (bus.rf_we && bus.rf_waddr == bus.rs_addr2));

    // Match both decode sources against the destination of every occupied FIFO slot
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hit1 = hit1 || (vld[i] && fifo_rd[i] == bus.rs_addr1);
            hit2 = hit2 || (vld[i] && fifo_rd[i] == bus.rs_addr2);
        end
    end

    // Load payload storage; occupancy lives in vld/count so reset need not clear it
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= bus.ld_rd;
            fifo_data[wr_ptr] <= bus.ld_data;
        end
    end

    // FIFO pointers, occupancy and the starvation counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            vld        <= '0;
            starve_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr      <= wr_ptr + AW'(1);
                vld[wr_ptr] <= 1'b1;
            end
            if (pop) begin
                rd_ptr      <= rd_ptr + AW'(1);
                vld[rd_ptr] <= 1'b0;
            end
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (!nonempty || pop)
                starve_cnt <= '0;
            else if (starve_cnt != SW'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // Register the arbitration winner; address/data hold when nothing wins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.rf_we    <= 1'b0;
            bus.rf_waddr <= '0;
            bus.rf_wdata <= '0;
        end else begin
            bus.rf_we <= alu_win || pop;
            if (alu_win || pop) begin
                bus.rf_waddr <= alu_win ? bus.alu_rd : fifo_rd[rd_ptr];
                bus.rf_wdata <= alu_win ? bus.alu_data : fifo_data[rd_ptr];
            end
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed stimulus with a write-port scoreboard for wb_arbiter
module tb_wb_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];

    wb_arbiter_if #(.XLEN(32)) bus ();

    wb_arbiter #(.DEPTH(4), .STARVE_LIMIT(3), .XLEN(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
        exp_q.push_back('{rd, data});
    endtask

    task automatic alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus.alu_valid = v;
        bus.alu_rd    = rd;
        bus.alu_data  = d;
    endtask

    task automatic ld(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus.ld_valid = v;
        bus.ld_rd    = rd;
        bus.ld_data  = d;
    endtask

    // Scoreboard monitor: every write-port pulse must match the next expected write
    initial begin
        wr_t w;
        forever begin
            @(negedge clk);
            if (bus.rf_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got rd %0d data %0h, expected no write", bus.rf_waddr, bus.rf_wdata);
                end else begin
                    w = exp_q.pop_front();
                    chk("wr_addr", 32'(bus.rf_waddr), 32'(w.rd));
                    chk("wr_data", bus.rf_wdata, w.data);
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: run did not complete within 20000 time units");
        $fatal(1);
    end

    initial begin
        alu(1'b0, 5'd0, 32'd0);
        ld(1'b0, 5'd0, 32'd0);
        bus.rs_addr1 = 5'd0;
        bus.rs_addr2 = 5'd0;
        step();
        chk1("reset_rf_we", bus.rf_we, 1'b0);
        chk("reset_rf_waddr", 32'(bus.rf_waddr), 32'd0);
        chk("reset_rf_wdata", bus.rf_wdata, 32'd0);
        chk1("reset_ld_ready", bus.ld_ready, 1'b1);
        chk1("reset_alu_ready", bus.alu_ready, 1'b1);
        rst = 1'b1;

        // Reset mid-FIFO: three loads held back by ALU traffic, then reset
        bus.rs_addr1 = 5'd2;
        bus.rs_addr2 = 5'd3;
        expect_wr(5'd1, 32'h100);
        expect_wr(5'd1, 32'h101);
        expect_wr(5'd1, 32'h102);
        alu(1'b1, 5'd1, 32'h100); ld(1'b1, 5'd2, 32'h200); step();
        alu(1'b1, 5'd1, 32'h101); ld(1'b1, 5'd3, 32'h300); step();
        alu(1'b1, 5'd1, 32'h102); ld(1'b1, 5'd4, 32'h400); step();
        alu(1'b0, 5'd0, 32'd0); ld(1'b0, 5'd0, 32'd0);
        chk1("queued_busy1", bus.busy1, 1'b1);
        chk1("queued_busy2", bus.busy2, 1'b1);
        chk1("queued_ld_ready", bus.ld_ready, 1'b1);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk1("midreset_ld_ready", bus.ld_ready, 1'b1);
        chk1("midreset_busy1", bus.busy1, 1'b0);
        chk1("midreset_busy2", bus.busy2, 1'b0);
        chk1("midreset_rf_we", bus.rf_we, 1'b0);
        #2;
        rst = 1'b1;
        step(); step(); step();
        chk1("post_reset_rf_we", bus.rf_we, 1'b0);

        // ALU alone: one-cycle latency
        bus.rs_addr1 = 5'd0;
        bus.rs_addr2 = 5'd0;
        expect_wr(5'd5, 32'hDEADBEEF);
        alu(1'b1, 5'd5, 32'hDEADBEEF);
        #1;
        chk1("alu_ready_alone", bus.alu_ready, 1'b1);
        step();
        chk1("alu_lat_we", bus.rf_we, 1'b1);
        chk("alu_lat_addr", 32'(bus.rf_waddr), 32'd5);
        chk("alu_lat_data", bus.rf_wdata, 32'hDEADBEEF);
        alu(1'b0, 5'd0, 32'd0);
        chk1("alu_ready_after", bus.alu_ready, 1'b1);
        step();
        chk1("alu_idle_we", bus.rf_we, 1'b0);

        // Fill with ALU always winning, then starvation forces the head load out
        for (int k = 0; k < 4; k++) expect_wr(5'(10 + k), 32'hA0 + 32'(k));
        expect_wr(5'd20, 32'hB0);
        expect_wr(5'd14, 32'hA4);
        expect_wr(5'd21, 32'hB1);
        expect_wr(5'd22, 32'hB2);
        expect_wr(5'd23, 32'hB3);
        for (int k = 0; k < 4; k++) begin
            alu(1'b1, 5'(10 + k), 32'hA0 + 32'(k));
            ld(1'b1, 5'(20 + k), 32'hB0 + 32'(k));
            step();
        end
        chk1("full_ld_ready", bus.ld_ready, 1'b0);
        chk1("starved_alu_ready", bus.alu_ready, 1'b0);
        alu(1'b1, 5'd14, 32'hA4);
        ld(1'b1, 5'd24, 32'hB4);
        step();
        chk("forced_pop_addr", 32'(bus.rf_waddr), 32'd20);
        chk1("forced_alu_ready_back", bus.alu_ready, 1'b1);
        ld(1'b0, 5'd0, 32'd0);
        chk1("after_pop_ld_ready", bus.ld_ready, 1'b1);
        step();
        alu(1'b0, 5'd0, 32'd0);
        step(); step(); step(); step();
        chk1("drained_rf_we", bus.rf_we, 1'b0);

        // x0 handling: ALU rd=0 lets a queued load pop; a load to rd=0 is dropped
        expect_wr(5'd7, 32'h77);
        alu(1'b1, 5'd0, 32'hFFFF);
        ld(1'b1, 5'd7, 32'h77);
        #1;
        chk1("x0_alu_ready", bus.alu_ready, 1'b1);
        step();
        chk1("x0_no_write", bus.rf_we, 1'b0);
        ld(1'b0, 5'd0, 32'd0);
        step();
        chk1("x0_pop_we", bus.rf_we, 1'b1);
        chk("x0_pop_addr", 32'(bus.rf_waddr), 32'd7);
        alu(1'b0, 5'd0, 32'd0);
        ld(1'b1, 5'd0, 32'h55);
        step();
        ld(1'b0, 5'd0, 32'd0);
        chk1("ld_x0_idle_we", bus.rf_we, 1'b0);
        step();
        chk1("ld_x0_dropped_we", bus.rf_we, 1'b0);
        step();

        // Hazard on a queued load destination, cleared after its write
        bus.rs_addr1 = 5'd9;
        bus.rs_addr2 = 5'd0;
        #1;
        chk1("hz_idle_busy1", bus.busy1, 1'b0);
        expect_wr(5'd1, 32'h1111);
        expect_wr(5'd9, 32'h99);
        alu(1'b1, 5'd1, 32'h1111);
        ld(1'b1, 5'd9, 32'h99);
        step();
        alu(1'b0, 5'd0, 32'd0);
        ld(1'b0, 5'd0, 32'd0);
        chk1("hz_fifo_busy1", bus.busy1, 1'b1);
        chk1("hz_busy2_x0", bus.busy2, 1'b0);
        step();
        chk("hz_write_addr", 32'(bus.rf_waddr), 32'd9);
        chk1("hz_write_busy1", bus.busy1, 1'b1);
        step();
        chk1("hz_clear_busy1", bus.busy1, 1'b0);
        chk1("hz_clear_we", bus.rf_we, 1'b0);
        bus.rs_addr1 = 5'd0;

        // Wrap-around: ten back-to-back loads with no ALU traffic
        for (int i = 0; i < 10; i++) begin
            expect_wr(5'(16 + i), 32'hC000_0000 + 32'(i * 32'h111));
            ld(1'b1, 5'(16 + i), 32'hC000_0000 + 32'(i * 32'h111));
            step();
        end
        ld(1'b0, 5'd0, 32'd0);
        step(); step(); step();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
